// File: rtl/generator_checker_if.sv
// Word stream and status bundle between a generator stream source and the checker.
interface generator_checker_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ERR_W  = 16;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              clear;
    logic              locked;
    logic              lost;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_count;
    logic [DATA_W-1:0] word_count;

    modport master (
        output in_valid, in_data, clear,
        input  locked, lost, err_pulse, err_count, word_count
    );

    modport slave (
        input  in_valid, in_data, clear,
        output locked, lost, err_pulse, err_count, word_count
    );
endinterface

// File: rtl/generator_checker.sv
// Self-synchronising checker for the shift/XOR generator word stream.
// Optional GENERATOR_CHECKER_AUTO_RELOCK_EN: LOST lasts one cycle, then SEARCH again.
module generator_checker #(
    parameter logic [31:0]       CONST      = 32'hFFFF_FFFF,
    parameter logic [3:0]        SHIFT_L1   = 4'hB,
    parameter logic [3:0]        SHIFT_L2   = 4'hB,
    parameter logic [3:0]        SHIFT_R    = 4'hB,
    parameter int unsigned       LOCK_COUNT = 4,
    parameter int unsigned       LOSS_COUNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    generator_checker_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ERR_W  = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } fsm_t;

    fsm_t              fsm;
    logic [DATA_W-1:0] state;
    logic [DATA_W-1:0] expected;
    logic [CNT_W-1:0]  match_cnt;
    logic [CNT_W-1:0]  miss_cnt;
    logic              match;
    logic              nonzero;

    // Next generator word predicted from the registered base.
    always_comb begin
        expected = (((state << SHIFT_L1) ^ state) >> SHIFT_R) ^ ((state & CONST) << SHIFT_L2);
        match    = (bus.in_data == expected);
        nonzero  = (bus.in_data != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm            <= SEARCH;
            state          <= '0;
            match_cnt      <= '0;
            miss_cnt       <= '0;
            bus.locked     <= 1'b0;
            bus.lost       <= 1'b0;
            bus.err_pulse  <= 1'b0;
            bus.err_count  <= '0;
            bus.word_count <= '0;
        end else begin
            bus.err_pulse <= 1'b0;
            if (bus.clear) begin
                fsm            <= SEARCH;
                match_cnt      <= '0;
                miss_cnt       <= '0;
                bus.locked     <= 1'b0;
                bus.lost       <= 1'b0;
                bus.err_count  <= '0;
                bus.word_count <= '0;
            end else begin
                case (fsm)
                    // Zero is a fixed point of the update, so it never seeds.
                    SEARCH: begin
                        if (bus.in_valid && nonzero) begin
                            state     <= bus.in_data;
                            match_cnt <= '0;
                            fsm       <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (bus.in_valid) begin
                            if (match) begin
                                state <= bus.in_data;
                                if (match_cnt == CNT_W'(LOCK_COUNT - 1)) begin
                                    match_cnt  <= '0;
                                    fsm        <= LOCKED;
                                    bus.locked <= 1'b1;
                                end else begin
                                    match_cnt <= match_cnt + CNT_W'(1);
                                end
                            end else if (nonzero) begin
                                state     <= bus.in_data;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= '0;
                                fsm       <= SEARCH;
                            end
                        end
                    end
                    // Flywheel on the prediction so single bit errors stay isolated.
                    LOCKED: begin
                        if (bus.in_valid) begin
                            state <= expected;
                            if (bus.word_count != '1) begin
                                bus.word_count <= bus.word_count + DATA_W'(1);
                            end
                            if (match) begin
                                miss_cnt <= '0;
                            end else begin
                                bus.err_pulse <= 1'b1;
                                if (bus.err_count != '1) begin
                                    bus.err_count <= bus.err_count + ERR_W'(1);
                                end
                                if (miss_cnt == CNT_W'(LOSS_COUNT - 1)) begin
                                    miss_cnt   <= '0;
                                    fsm        <= LOST;
                                    bus.locked <= 1'b0;
                                    bus.lost   <= 1'b1;
                                end else begin
                                    miss_cnt <= miss_cnt + CNT_W'(1);
                                end
                            end
                        end
                    end
                    LOST: begin
`ifdef GENERATOR_CHECKER_AUTO_RELOCK_EN
                        fsm       <= SEARCH;
                        match_cnt <= '0;
                        miss_cnt  <= '0;
                        bus.lost  <= 1'b0;
`else
                        fsm <= LOST;
`endif
                    end
                    default: begin
                        fsm <= SEARCH;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_generator_checker.sv
// Randomised scoreboard bench for generator_checker against a queue-based reference model.
module tb_generator_checker;
    localparam logic [31:0] CONST      = 32'hFFFF_FFFF;
    localparam int          SL1        = 11;
    localparam int          SL2        = 11;
    localparam int          SR         = 11;
    localparam int          LOCK_COUNT = 4;
    localparam int          LOSS_COUNT = 4;

    typedef struct packed {
        logic        locked;
        logic        lost;
        logic        pulse;
        logic [15:0] err;
        logic [31:0] words;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    generator_checker_if bus ();

    generator_checker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    obs_t sb[$];

    // Reference model: mode names, a candidate chain queue and plain counters.
    typedef enum int {M_SEARCH, M_VERIFY, M_LOCKED, M_LOST} mode_t;
    mode_t       m_mode;
    logic [31:0] run[$];
    logic [31:0] m_base;
    int          m_misses;
    bit          m_pulse;
    longint      m_err;
    longint      m_words;
    logic [31:0] gen;

    function automatic logic [31:0] f(input logic [31:0] s);
        logic [31:0] a;
        a = s << SL1;
        a = a ^ s;
        a = a >> SR;
        return a ^ ((s & CONST) << SL2);
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.locked = (m_mode == M_LOCKED);
        o.lost   = (m_mode == M_LOST);
        o.pulse  = m_pulse;
        o.err    = (m_err > 65535) ? 16'hFFFF : 16'(m_err);
        o.words  = (m_words > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_words);
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.locked = bus.locked;
        o.lost   = bus.lost;
        o.pulse  = bus.err_pulse;
        o.err    = bus.err_count;
        o.words  = bus.word_count;
        return o;
    endfunction

    task automatic model_reset();
        m_mode   = M_SEARCH;
        run      = {};
        m_base   = '0;
        m_misses = 0;
        m_pulse  = 1'b0;
        m_err    = 0;
        m_words  = 0;
    endtask

    task automatic model_step(input bit v, input logic [31:0] d, input bit c);
        m_pulse = 1'b0;
        if (c) begin
            m_mode   = M_SEARCH;
            run      = {};
            m_misses = 0;
            m_err    = 0;
            m_words  = 0;
        end else if (m_mode == M_LOST) begin
`ifdef GENERATOR_CHECKER_AUTO_RELOCK_EN
            m_mode   = M_SEARCH;
            run      = {};
            m_misses = 0;
`endif
        end else if (v) begin
            if (m_mode == M_SEARCH) begin
                if (d != 0) begin
                    run    = {d};
                    m_mode = M_VERIFY;
                end
            end else if (m_mode == M_VERIFY) begin
                // Lock once the seed plus LOCK_COUNT successors form an unbroken chain.
                if (d == f(run[$])) begin
                    run.push_back(d);
                    if (run.size() == LOCK_COUNT + 1) begin
                        m_base   = d;
                        m_misses = 0;
                        m_mode   = M_LOCKED;
                    end
                end else if (d != 0) begin
                    run = {d};
                end else begin
                    run    = {};
                    m_mode = M_SEARCH;
                end
            end else begin
                m_words++;
                m_base = f(m_base);
                if (d == m_base) begin
                    m_misses = 0;
                end else begin
                    m_pulse = 1'b1;
                    m_err++;
                    m_misses++;
                    if (m_misses == LOSS_COUNT) m_mode = M_LOST;
                end
            end
        end
    endtask

    task automatic check(input string name, input obs_t got, input obs_t want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got locked=%b lost=%b pulse=%b err=%0d words=%0d, want locked=%b lost=%b pulse=%b err=%0d words=%0d",
                     name, $time, got.locked, got.lost, got.pulse, got.err, got.words,
                     want.locked, want.lost, want.pulse, want.err, want.words);
        end
    endtask

    // Monitor: one registered response per driven cycle, sampled after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) check("beat", dut_obs(), sb.pop_front());
        end
    end

    task automatic drive(input bit v, input logic [31:0] d, input bit c);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.clear    = c;
        model_step(v, d, c);
        sb.push_back(model_obs());
    endtask

    function automatic logic [31:0] next_gen();
        gen = f(gen);
        if (gen == 0) gen = 32'hFFFF_FFFF;
        return gen;
    endfunction

    // Asynchronous reset taken mid-cycle after the scoreboard has drained.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
        #1;
        model_reset();
        check("async_reset", dut_obs(), model_obs());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic lock_from(input logic [31:0] seed);
        gen = seed;
        drive(1'b1, gen, 1'b0);
        repeat (LOCK_COUNT) drive(1'b1, next_gen(), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int err_rate;
        int r;
        logic [31:0] w;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.clear    = 1'b0;
        model_reset();
        #1;
        check("reset_state", dut_obs(), model_obs());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Lock on the known chain, then keep checking correct words.
        lock_from(32'hFFFF_FFFF);
        repeat (3) drive(1'b1, next_gen(), 1'b0);
        // Single bit flip while locked.
        drive(1'b1, next_gen() ^ 32'h1, 1'b0);
        repeat (2) drive(1'b1, next_gen(), 1'b0);
        // Consecutive bad words lose lock; observe LOST behaviour with traffic.
        repeat (LOSS_COUNT) drive(1'b1, next_gen() ^ 32'h0000_0080, 1'b0);
        repeat (3) drive(1'b1, next_gen(), 1'b0);
        drive(1'b0, '0, 1'b1);

        // Zero words never seed, then a real chain locks.
        repeat (3) drive(1'b1, 32'h0, 1'b0);
        lock_from(32'hFFFF_FFFF);
        drive(1'b0, '0, 1'b1);

        // Wrong second word reseeds the verify chain.
        drive(1'b1, 32'hFFFF_FFFF, 1'b0);
        lock_from(32'h1234_5678);

        // Three errors while locked, then clear wins over a valid beat.
        repeat (3) drive(1'b1, next_gen() ^ 32'h8000_0000, 1'b0);
        drive(1'b1, next_gen(), 1'b1);
        drive(1'b0, '0, 1'b0);

        // Random traffic: idles, error bursts, zeros and occasional clears.
        gen      = $urandom() | 32'h1;
        err_rate = 5;
        for (int i = 0; i < 1500; i++) begin
            if (i % 60 == 0) err_rate = (err_rate == 5) ? 55 : 5;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                drive(1'($urandom_range(0, 1)), $urandom(), 1'b1);
            end else if (r < 23) begin
                drive(1'b0, $urandom(), 1'b0);
            end else begin
                w = next_gen();
                if (int'($urandom_range(0, 99)) < err_rate) w = w ^ (32'h1 << $urandom_range(0, 31));
                if (int'($urandom_range(0, 99)) == 0) w = '0;
                drive(1'b1, w, 1'b0);
            end
        end

        // Mid-stream asynchronous reset, then a fresh lock.
        drive(1'b0, '0, 1'b1);
        lock_from(32'hFFFF_FFFF);
        drive(1'b1, next_gen() ^ 32'h10, 1'b0);
        do_reset();
        lock_from(32'hFFFF_F800);
        repeat (2) drive(1'b1, next_gen(), 1'b0);

        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
